// File: rtl/run_det_pkg.sv
// run_det_pkg: shared state encoding for the run-length detector
package run_det_pkg;
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_SAT  = 2'b10
    } state_t;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: up-counter that sticks at all-ones, with sync clear and hold
module sat_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         hold,
    input  logic         inc,
    output logic [W-1:0] q
);
    // clear beats hold; increment stops at all-ones instead of wrapping
    always_ff @(posedge clk) begin
        if (!rst || clr)
            q <= '0;
        else if (!hold && inc && q != '1)
            q <= q + W'(1);
    end
endmodule

// File: rtl/run_length_detector.sv
// run_length_detector: measures runs of an active symbol and pulses when a qualifying run ends
module run_length_detector
    import run_det_pkg::*;
#(
    parameter int CNT_W   = 4,
    parameter int MIN_RUN = 1,
    parameter int TALLY_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               clr,
    input  logic               polarity,
    input  logic               in,
    output logic               out,
    output logic [CNT_W-1:0]   run_len,
    output logic               sat,
    output logic [TALLY_W-1:0] run_count,
    output logic [1:0]         out_state
);
    localparam logic [CNT_W-1:0] MAXC    = '1;
    localparam logic [CNT_W-1:0] MIN_L   = CNT_W'(MIN_RUN);
    localparam bit               ONE_MAX = (CNT_W == 1);

    state_t           state, state_nx;
    logic             mode, eff_mode, b, end_run, cnt_inc, qualify;
    logic [CNT_W-1:0] cnt;

    // next state, counter strobes and run-end qualification; in IDLE the incoming polarity is used immediately
    always_comb begin
        eff_mode = (state == ST_IDLE) ? polarity : mode;
        b        = in ^ eff_mode;
        state_nx = state;
        end_run  = 1'b0;
        cnt_inc  = 1'b0;
        case (state)
            ST_IDLE: begin
                cnt_inc  = b;
                state_nx = !b ? ST_IDLE : (ONE_MAX ? ST_SAT : ST_RUN);
            end
            ST_RUN: begin
                cnt_inc  = b;
                end_run  = !b;
                state_nx = !b ? ST_IDLE : ((cnt + CNT_W'(1) == MAXC) ? ST_SAT : ST_RUN);
            end
            ST_SAT: begin
                cnt_inc  = b;
                end_run  = !b;
                state_nx = b ? ST_SAT : ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
        qualify = en && end_run && (cnt >= MIN_L);
    end

    // state, captured polarity and registered pulse outputs
    always_ff @(posedge clk) begin
        if (!rst || clr) begin
            state   <= ST_IDLE;
            mode    <= 1'b0;
            out     <= 1'b0;
            run_len <= '0;
            sat     <= 1'b0;
        end else if (!en) begin
            out <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == ST_IDLE)
                mode <= polarity;
            out <= qualify;
            if (qualify) begin
                run_len <= cnt;
                sat     <= (state == ST_SAT);
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr || (en && end_run)),
        .hold (!en),
        .inc  (cnt_inc),
        .q    (cnt)
    );

    sat_counter #(.W(TALLY_W)) u_tally (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr),
        .hold (!en),
        .inc  (qualify),
        .q    (run_count)
    );

    assign out_state = state;
endmodule

// File: doc/run_length_detector.md
Name: run_length_detector

Overview:
- Parametrised successor to the lab's 4-state "end of 1-run" detector.
- Tracks consecutive active symbols on serial input `in`, using a counter of configurable width.
- When a qualifying run ends, it emits a one-cycle pulse with the run length, a saturation flag and a running tally of runs.
- Sits after a synchronised serial input, e.g. debounced switch or bitstream, feeding LEDs/7-seg display logic.

Parameters:
CNT_W, 4, width of run-length counter; max countable run = 2^CNT_W-1 (15)
MIN_RUN, 1, shortest run that produces a pulse; legal range 1..2^CNT_W-1
TALLY_W, 8, width of saturating run tally counter

Ports:
clk  in  1  system clock, all logic on posedge
rst  in  1  synchronous active-low reset, sampled on posedge clk only
en  in  1  sample enable; when 0 the block holds all state
clr  in  1  synchronous clear of FSM, counters and outputs
polarity  in  1  0 = count runs of 1s, 1 = count runs of 0s
in  in  1  serial data bit
out  out  1  one-cycle pulse: qualifying run just ended
run_len  out  CNT_W  length of the run that ended, valid while out=1, held otherwise
sat  out  1  run reached 2^CNT_W-1; updated with out
run_count  out  TALLY_W  number of qualifying runs, saturating
out_state  out  2  current FSM state

Behaviour:
- Priority, highest first: rst=0 > clr=1 > en=0 > normal operation.
- rst=0 or clr=1 at posedge:
  - state=IDLE, cnt=0, mode=0, out=0, run_len=0, sat=0, run_count=0, out_state=2'b00.
  - Reset/clear mid-run discards the run; no pulse is produced.
- en=0: state, cnt, mode, run_len, sat and run_count hold; out forced 0.
- Active symbol: b = in XOR mode.
- mode is loaded from polarity only on cycles where state=IDLE. Polarity changes during RUN or SAT are ignored until the next return to IDLE.
- FSM states and encodings: IDLE=2'b00, RUN=2'b01, SAT=2'b10. 2'b11 is illegal and recovers to IDLE.
- IDLE: b=1 -> RUN, cnt=1 (or SAT if 2^CNT_W-1 == 1). b=0 -> stay.
- RUN:
  - b=1 -> cnt=cnt+1; if cnt+1 == 2^CNT_W-1 then go to SAT.
  - b=0 -> IDLE and end the run.
- SAT: b=1 -> stay, cnt holds at 2^CNT_W-1 (no wrap). b=0 -> IDLE and end the run.
- Run end, with L = cnt before clearing:
  - If L >= MIN_RUN: out=1 for exactly one cycle, run_len=L, sat=(state was SAT), run_count=run_count+1 saturating at 2^TALLY_W-1.
  - If L < MIN_RUN: no pulse; run_len, sat and run_count unchanged.
  - In both cases cnt=0.
- Latency: the posedge that samples the terminating symbol sets out=1, so out is visible in the following cycle. It then deasserts at the next posedge unless a new run ends there.
- Back-to-back runs: a single terminating symbol then an active symbol -> IDLE for one cycle, then RUN. The minimum pulse spacing is 2 cycles.
- All outputs are registered; out_state equals the state register.

Decomposition:
- Shared package run_det_pkg holds:
  - State encoding constants ST_IDLE, ST_RUN, ST_SAT.
  - The 2-bit state typedef.
- One natural sub-module, sat_counter: parametrised width, with inc, clr and hold inputs, saturating at all-ones. Instantiated twice: once for cnt (CNT_W) and once for run_count (TALLY_W).
- The FSM and output registers stay in run_length_detector.

Test Plan:
1. Reset check:
   - Drive rst=0 between clock edges -> no change until the next posedge.
   - After that posedge: out=0, run_len=0, sat=0, run_count=0, out_state=00.
2. Basic run (defaults, polarity=0):
   - in = 0,1,1,1,0 -> out_state goes 00,01,01,01,00.
   - out=1 for one cycle after the 0 is sampled, with run_len=3, sat=0, run_count=1.
3. Saturation:
   - in=1 for 20 cycles, then 0 -> out_state=10 from the 15th 1 onward.
   - Pulse with run_len=15, sat=1; cnt never wraps.
4. Minimum run (MIN_RUN=3 instance):
   - A run of 2 -> no pulse, run_count stays 0.
   - A run of 3 -> pulse, run_len=3, run_count=1.
5. Polarity:
   - polarity=1, in = 1,0,0,0,0,1 -> run_len=4.
   - Toggling polarity during that run -> same result.
6. Interruptions:
   - en=0 for 5 cycles mid-run of length 2, then 2 more 1s and a 0 -> run_len=4.
   - rst=0 mid-run -> IDLE, no pulse.
   - run_count=255 plus another run -> stays 255.
